// File: rtl/winv_loader_pkg.sv
// Shared constants for the WINV loader and the WINV storage banks it fills.
// DEPTH is the per-bank entry count; the banks must use the same expression.
package winv_loader_pkg;

   localparam int unsigned RING_DEPTH = 4;
   localparam int unsigned PE_DEPTH   = 2;
   localparam int unsigned DEPTH      = ((1 << (RING_DEPTH - PE_DEPTH)) - 1) + PE_DEPTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A counter over n values needs at least one bit, even when n == 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/winv_loader_addr_gen.sv
// Bank/address counter pair for the WINV loader: bank-minor ordering, and a flag
// that marks the final slot (last bank, address DEPTH-1).
module winv_loader_addr_gen
   import winv_loader_pkg::*;
#(
   parameter int unsigned HLEN   = 9,
   parameter int unsigned PE_NUM = 4,
   parameter int unsigned BW     = cnt_width(PE_NUM)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            adv_i,
   output logic [BW-1:0]   bank_o,
   output logic [HLEN-1:0] addr_o,
   output logic            last_o
);

   logic [BW-1:0]   bank_q, bank_d;
   logic [HLEN-1:0] addr_q, addr_d;
   logic            bank_wrap;

   assign bank_wrap = (bank_q == BW'(PE_NUM - 1));
   assign last_o    = bank_wrap && (addr_q == HLEN'(DEPTH - 1));
   assign bank_o    = bank_q;
   assign addr_o    = addr_q;

   // Counters park on the final slot so the address can never pass DEPTH-1.
   always_comb begin
      bank_d = bank_q;
      addr_d = addr_q;
      if (clr_i) begin
         bank_d = '0;
         addr_d = '0;
      end else if (adv_i && !last_o) begin
         if (bank_wrap) begin
            bank_d = '0;
            addr_d = addr_q + 1'b1;
         end else begin
            bank_d = bank_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= '0;
         addr_q <= '0;
      end else begin
         bank_q <= bank_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/winv_loader.sv
// Streams twiddle words round-robin into PE_NUM WINV bank write ports.
// Optional WINV_LOADER_CHKSUM_EN adds chk_sum, the mod-2^DLEN sum of accepted words.
module winv_loader
   import winv_loader_pkg::*;
#(
   parameter int unsigned DLEN   = 32,
   parameter int unsigned HLEN   = 9,
   parameter int unsigned PE_NUM = 1 << PE_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              win_valid,
   input  logic [DLEN-1:0]   win_data,
   output logic              win_ready,
   output logic [PE_NUM-1:0] wen,
   output logic [HLEN-1:0]   waddr,
   output logic [DLEN-1:0]   wdata,
   output logic              busy,
   output logic              done
`ifdef WINV_LOADER_CHKSUM_EN
   ,
   output logic [DLEN-1:0]   chk_sum
`endif
);

   localparam int unsigned BW = cnt_width(PE_NUM);

   state_e            state_q, state_d;
   logic              accept;
   logic              clr;
   logic              last;
   logic [BW-1:0]     bank;
   logic [HLEN-1:0]   addr;
   logic [PE_NUM-1:0] wen_q, wen_d;
   logic [HLEN-1:0]   waddr_q, waddr_d;
   logic [DLEN-1:0]   wdata_q, wdata_d;

   assign win_ready = (state_q == ST_LOAD);
   assign busy      = (state_q == ST_LOAD);
   assign done      = (state_q == ST_DONE);
   assign accept    = win_valid && win_ready;
   assign clr       = start && (state_q != ST_LOAD);

   winv_loader_addr_gen #(
      .HLEN   (HLEN),
      .PE_NUM (PE_NUM),
      .BW     (BW)
   ) u_addr_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .adv_i  (accept),
      .bank_o (bank),
      .addr_o (addr),
      .last_o (last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: if (accept && last) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wen_d   = '0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (accept) begin
         for (int unsigned b = 0; b < PE_NUM; b++) begin
            wen_d[b] = (bank == BW'(b));
         end
         waddr_d = addr;
         wdata_d = win_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wen_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign wen   = wen_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;

`ifdef WINV_LOADER_CHKSUM_EN
   logic [DLEN-1:0] sum_q, sum_d;

   // Registered alongside the write stage so the sum lines up with the bus.
   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (accept) begin
         sum_d = sum_q + win_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign chk_sum = sum_q;
`endif

endmodule

// File: tb/tb_winv_loader.sv
// Self-checking bench for winv_loader (PE_NUM=4, DEPTH=5) with an arithmetic
// reference model; chk_sum is checked when WINV_LOADER_CHKSUM_EN is defined.
module tb_winv_loader;

   localparam int unsigned PE    = 4;
   localparam int unsigned DEP   = 5;
   localparam int unsigned TOTAL = PE * DEP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          win_valid = 1'b0;
   logic [31:0]   win_data = '0;
   logic          win_ready;
   logic [PE-1:0] wen;
   logic [8:0]    waddr;
   logic [31:0]   wdata;
   logic          busy;
   logic          done;
`ifdef WINV_LOADER_CHKSUM_EN
   logic [31:0]   chk_sum;
`endif

   winv_loader #(
      .DLEN   (32),
      .HLEN   (9),
      .PE_NUM (PE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .win_valid (win_valid),
      .win_data  (win_data),
      .win_ready (win_ready),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
`ifdef WINV_LOADER_CHKSUM_EN
      ,
      .chk_sum   (chk_sum)
`endif
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          busy_cyc = 0;
   int          bad_wr   = 0;
   bit          m_load   = 1'b0;
   bit          m_done   = 1'b0;
   int unsigned m_n      = 0;
   logic [31:0] m_sum    = '0;
   logic [31:0] words    [TOTAL];
   logic [31:0] bank_mem [PE][DEP];

   // Behaves as the bank RAMs: captures every write seen on the bus.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int b = 0; b < PE; b++) begin
            if (wen[b]) begin
               if (waddr < DEP) bank_mem[b][waddr] = wdata;
               else bad_wr++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", win_ready, 0);
      chk("rst_wen",   wen,       0);
      chk("rst_waddr", waddr,     0);
      chk("rst_wdata", wdata,     0);
      chk("rst_busy",  busy,      0);
      chk("rst_done",  done,      0);
`ifdef WINV_LOADER_CHKSUM_EN
      chk("rst_sum",   chk_sum,   0);
`endif
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cyc(input logic v, input logic [31:0] d, input logic st);
      logic [PE-1:0] ew;
      logic          acc;
      int unsigned   ea;
      chk("ready", win_ready, m_load);
      chk("busy",  busy,      m_load);
      chk("done",  done,      m_done);
      if (busy === 1'b1) busy_cyc++;
      win_valid = v;
      win_data  = d;
      start     = st;
      @(posedge clk);
      ew  = '0;
      ea  = 0;
      acc = v && m_load;
      if (acc) begin
         ew[m_n % PE] = 1'b1;
         ea           = m_n / PE;
         words[m_n]   = d;
         m_sum        = m_sum + d;
         m_n++;
         if (m_n == TOTAL) begin
            m_load = 1'b0;
            m_done = 1'b1;
         end
      end else if (st && !m_load) begin
         m_load = 1'b1;
         m_done = 1'b0;
         m_n    = 0;
         m_sum  = '0;
      end
      @(negedge clk);
      chk("wen", wen, ew);
      if (acc) begin
         chk("waddr", waddr, ea);
         chk("wdata", wdata, d);
      end
`ifdef WINV_LOADER_CHKSUM_EN
      chk("chk_sum", chk_sum, m_sum);
`endif
   endtask

   task automatic begin_load();
      busy_cyc = 0;
      for (int b = 0; b < PE; b++)
         for (int a = 0; a < DEP; a++)
            bank_mem[b][a] = 'x;
   endtask

   task automatic check_image();
      for (int b = 0; b < PE; b++)
         for (int a = 0; a < DEP; a++)
            chk($sformatf("img_b%0d_a%0d", b, a), bank_mem[b][a], words[a * PE + b]);
   endtask

   initial begin
      int g;
      logic v;

      // Reset values
      #12;
      chk_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back 0..19: bank b, address a receives 4a+b
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, i, 1'b0);
      chk("done_after_20", done, 1);
`ifdef WINV_LOADER_CHKSUM_EN
      chk("sum_190", chk_sum, 32'd190);
`endif
      cyc(1'b0, 32'd0, 1'b0);
      cyc(1'b1, 32'hDEAD, 1'b0);
      check_image();
      chk("map_b2_a3", bank_mem[2][3], 32'd14);

      // Alternating valid: 39 cycles in LOAD, no writes on idle cycles
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 2 * TOTAL - 1; i++) cyc((i % 2) == 0, i / 2, 1'b0);
      chk("load_cycles_39", busy_cyc, 39);
      cyc(1'b0, 32'd0, 1'b0);
      check_image();

      // Random valid/data with a start pulse mid-load after 7 words
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      g = 0;
      while (!m_done && g < 400) begin
         v = ($urandom_range(0, 3) != 0);
         cyc(v, $urandom, (m_n == 7) && v);
         g++;
      end
      chk("done_random", done, 1);
      cyc(1'b0, 32'd0, 1'b0);
      check_image();

      // Asynchronous reset after 10 words, then a full reload
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b0);
      rst_n     = 1'b0;
      win_valid = 1'b0;
      #1;
      chk_reset_outputs();
      m_load = 1'b0;
      m_done = 1'b0;
      m_n    = 0;
      m_sum  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      begin_load();
      cyc(1'b1, 32'd0, 1'b1);
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, $urandom, 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
      check_image();

      // All-ones words: sum wraps to -20
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, 32'hFFFF_FFFF, 1'b0);
`ifdef WINV_LOADER_CHKSUM_EN
      chk("sum_ffffffec", chk_sum, 32'hFFFF_FFEC);
`endif
      cyc(1'b0, 32'd0, 1'b0);
      check_image();

      // Restart from DONE with 100..119
      begin_load();
      cyc(1'b0, 32'd0, 1'b1);
      chk("done_dropped", done, 0);
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, 100 + i, 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
      check_image();
      chk("b3_a4_119", bank_mem[3][4], 32'd119);
      chk("no_out_of_range_writes", bad_wr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/winv_loader.md
# winv_loader

Runtime writer for the per-PE inverse-twiddle (WINV) storage banks. It accepts a valid/ready stream of twiddle words from the host side and scatters them round-robin across `PE_NUM` bank write ports. Each bank's read-only consumer sees the same contents it would get from a preloaded image, so twiddle sets can be swapped without resynthesis. It sits between the host/DMA interface and the WINV bank RAMs, which are instantiated as simple dual-port RAMs: one write port from this block, one read port to the PE.

## Interface
- `DLEN`, default 32: twiddle word width.
- `HLEN`, default 9: bank address width.
- `PE_NUM`, default `1<<PE_DEPTH`: number of banks / PEs.
- `DEPTH` (localparam): `((1<<(RING_DEPTH-PE_DEPTH))-1)+PE_DEPTH`, the entries per bank.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a load.
- `win_valid`, in, 1: stream word valid.
- `win_data`, in, DLEN: stream word.
- `win_ready`, out, 1: stream ready.
- `wen`, out, PE_NUM: one-hot bank write enable.
- `waddr`, out, HLEN: bank write address, shared by all banks.
- `wdata`, out, DLEN: bank write data, shared by all banks.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: all `PE_NUM*DEPTH` words have been written.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE→LOAD on `start`. DONE→LOAD on `start`, which clears `done`. `start` while in LOAD is ignored.
- In LOAD, `win_ready` is 1. In IDLE and DONE it is 0. A word is accepted when `win_valid & win_ready`.
- Ordering is bank-minor: accepted word index i goes to bank `i % PE_NUM` at address `i / PE_NUM`.
- Counters: `bank_cnt` counts 0..PE_NUM-1 and wraps to 0 while incrementing `addr_cnt`. `addr_cnt` counts 0..DEPTH-1.
- Accepting the word with `bank_cnt==PE_NUM-1` and `addr_cnt==DEPTH-1` moves the FSM to DONE. No further words are accepted and no writes occur past DEPTH-1.
- Both counters reset to 0 on every transition into LOAD.
- Stalls (`win_valid`=0) hold all counters. No write is issued during a stall.
- `waddr` never exceeds DEPTH-1. HLEN must satisfy `(1<<HLEN) >= DEPTH`.

## Timing
- Reset values: `win_ready`=0, `wen`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0.
- `win_ready` and `busy` are decoded from the state register (no combinational path from `win_valid`). Both are 1 exactly while in LOAD.
- Write latency is 1 cycle. A word accepted on edge N drives `wen[bank]`=1, `waddr`, `wdata` on the cycle after edge N, for exactly one cycle.
- Full throughput: one word per cycle is sustained.
- The final word is accepted on edge N. On the cycle after N the state is DONE, `done`=1, `busy`=0, and the last write is on the bus in that same cycle.
- `done` stays high until the next `start` or reset.
- Reset mid-load: asynchronous return to IDLE with all outputs at reset values. Bank contents are partially written and undefined, so a new `start` is required.
- `start` and `win_valid` in the same IDLE cycle: the FSM enters LOAD. The word is not accepted that cycle because `win_ready` was 0.

## Configuration
- `WINV_LOADER_CHKSUM_EN` defined: adds output `chk_sum` [DLEN-1:0], the sum of all accepted words mod 2^DLEN. It resets to 0 on `rst_n` and on entry into LOAD, updates on the same cycle as the corresponding write, and is final when `done` rises.
- Undefined: no `chk_sum` port and no adder logic.

## Structure
- Shared package/defines: `RING_DEPTH`, `PE_DEPTH`, the derived `DEPTH` expression (shared with the WINV storage banks), and the FSM state encoding.
- Sub-module `winv_loader_addr_gen`: the bank/address counter pair with wrap and last-word flag.
- The FSM, write register stage and optional checksum stay at top level.

## Test plan
Tests run with `RING_DEPTH`=4 and `PE_DEPTH`=2, so `PE_NUM`=4, `DEPTH`=5 and 20 words per load.
- Reset, then `start` with `win_data` = 0..19 streamed back to back → bank b, address a receives value 4a+b. `done` rises on the cycle after the 20th acceptance, and `win_ready` is low thereafter.
- Same stream with `win_valid` toggling 1,0,1,0 → identical bank contents, no `wen` during idle cycles, 39-cycle load.
- `start` pulsed mid-load after 7 words → ignored: load completes at 20 words with the correct map.
- `rst_n` asserted after 10 words → all outputs 0 immediately. A new `start` plus 20 words yields the full correct map.
- `WINV_LOADER_CHKSUM_EN` with data 0..19 → `chk_sum`=190 at `done`. A reload with all words 0xFFFFFFFF → `chk_sum`=0xFFFFFFEC.
- Load completes, then `start` in DONE → `done` drops the next cycle and a second load of data 100..119 overwrites every entry, with bank 3, address 4 = 119.
